register_file_reader: RTL and testbench
=======================================

# register_file_reader

Sequential dump engine that walks a contiguous, wrap-around range of architectural registers through one read port of the 32x32 register file. It presents each register value, with its index, on a valid/ready output stream. It sits beside the register file and drives a read-address port as the consumer of the data the write port stores. Uses are debug/trace readout, context save, and testbench state comparison.

## Interface

- ADDR_WIDTH, 5: register index width (32 registers).
- DATA_WIDTH, 32: register data width.

- Clk  input  1  rising-edge clock shared with the register file.
- Rst_n  input  1  reset, asynchronous, active-low.
- Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- Abort  input  1  synchronous cancel; takes effect in any state.
- FirstReg  input  ADDR_WIDTH  first index to dump; latched with Start.
- LastReg  input  ADDR_WIDTH  last index to dump; latched with Start.
- ReadRegister  output  ADDR_WIDTH  address to the register-file read port.
- ReadData  input  DATA_WIDTH  combinational read data returned for ReadRegister.
- OutValid  output  1  OutData/OutIndex hold a word.
- OutReady  input  1  consumer accepts the word when OutValid&OutReady at a rising edge.
- OutData  output  DATA_WIDTH  captured register value.
- OutIndex  output  ADDR_WIDTH  index of OutData.
- Busy  output  1  high in READ and HOLD.
- Done  output  1  one-cycle pulse after the last word is accepted.

## Operation

- Internal registers: 2-bit state, Cur (current index), Last (latched end index).
- Output roles: ReadRegister = Cur in every state. All other outputs are registered.
- IDLE:
  - Start=1 at an edge (and Abort=0): Cur<=FirstReg, Last<=LastReg, go to READ.
  - Start outside IDLE is ignored.
- READ, one cycle:
  - At the edge: OutData<=ReadData, OutIndex<=Cur, OutValid<=1, go to HOLD.
- HOLD:
  - OutValid, OutData and OutIndex stay stable until the handshake.
  - On OutValid&OutReady with Cur==Last: OutValid<=0, go to DONE.
  - On OutValid&OutReady with Cur!=Last: OutValid<=0, Cur<=Cur+1 (mod 32), go to READ.
- DONE, one cycle: Done=1, then go to IDLE.
- Range arithmetic: indices increment modulo 2^ADDR_WIDTH.
  - Word count = ((LastReg-FirstReg) mod 32)+1.
  - FirstReg==LastReg dumps 1 word.
  - LastReg==FirstReg-1 dumps all 32.
  - FirstReg>LastReg wraps through 31 to 0.
- Abort=1 at an edge:
  - From any state, go to IDLE with OutValid<=0 and Done<=0.
  - A pending word is discarded; no Done is issued.
  - Abort has priority over Start and over the handshake in the same cycle.
- Register 0 is dumped as whatever the register file returns; no special-casing.
- Concurrent writes: the captured value is the register-file content before any write committed at the same edge (write-then-read in one cycle returns the old value).

## Timing

- Reset (Rst_n=0, asynchronous): state=IDLE, Cur=0, Last=0, ReadRegister=0, OutValid=0, OutData=0, OutIndex=0, Busy=0, Done=0.
- Start accepted at edge E0:
  - Word k becomes valid after edge E(1+2k+s), where s is the number of stall cycles so far.
  - Zero-stall throughput is 1 word per 2 cycles.
- Done is high for exactly the cycle after the final handshake edge. Busy drops at that same edge.
- New Start is accepted at earliest in the cycle after Done (IDLE).
- Reset mid-dump: all outputs return to reset values immediately; no Done pulse.

## Test plan

1. **Full dump.** Preload Ri=32'h0000_0100+i, FirstReg=0, LastReg=31, OutReady=1, Start at E0.
   - Words are 0x100..0x11F in index order 0..31.
   - Word k is valid after E(1+2k).
   - Done pulses after E64.
2. **Backpressure.** Same setup, OutReady=0 for 5 cycles while word 3 is valid.
   - OutData=0x103 and OutIndex=3 stay stable.
   - No skipped or duplicated index.
   - Done is delayed by exactly 5 cycles.
3. **Wrap.** FirstReg=30, LastReg=1.
   - Indices 30,31,0,1 with matching data, then Done.
   - Busy is high for exactly 8 cycles.
4. **Single and full-ring edges.** FirstReg=LastReg=7 gives 1 word (index 7).
   - FirstReg=5, LastReg=4 gives 32 words (5..31, 0..4).
5. **Abort.** Assert Abort in HOLD after 3 accepted words.
   - OutValid=0 and Busy=0 next cycle; no Done.
   - Immediate new Start (0..0) dumps 1 word correctly.
   - A Start pulse during the original dump is ignored.
6. **Reset and write collision.**
   - Drop Rst_n mid-HOLD: outputs zero asynchronously.
   - Write R9=0xDEAD_BEEF at the edge that captures R9 (old value 0x109): OutData=0x109.

Source files
------------

// File: rtl/register_file_reader_if.sv
// register_file_reader_if
//   Bundles the two buses the dump engine talks on:
//     - register-file read port: ReadRegister (address out), ReadData (combinational data in)
//     - output word stream: OutValid/OutReady handshake carrying OutData and OutIndex
//   master: the dump engine (drives address and stream).
//   slave : the register file plus the stream consumer.
// Handshake: a word transfers at a rising edge where OutValid && OutReady. While
// OutValid is high and OutReady is low, OutData/OutIndex are held stable. OutReady
// may toggle freely; OutValid never drops without a transfer except on Abort/reset.
interface register_file_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ReadRegister;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  OutValid;
  logic                  OutReady;
  logic [DATA_WIDTH-1:0] OutData;
  logic [ADDR_WIDTH-1:0] OutIndex;

  modport master (
    output ReadRegister,
    input  ReadData,
    output OutValid,
    input  OutReady,
    output OutData,
    output OutIndex
  );

  modport slave (
    input  ReadRegister,
    output ReadData,
    input  OutValid,
    output OutReady,
    input  OutData,
    input  OutIndex
  );
endinterface

// File: rtl/register_file_reader.sv
// register_file_reader
//   Walks a wrap-around range of register indices [FirstReg..LastReg] through one
//   read port of the register file and emits each value with its index on a
//   valid/ready stream. Two cycles per word without backpressure: READ captures,
//   HOLD waits for the handshake.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Start               begin a dump (only honoured in IDLE)
//   Abort               synchronous cancel, highest priority
//   FirstReg, LastReg   range, latched with Start
//   Busy                high in READ and HOLD (registered)
//   Done                one-cycle pulse after the final word is accepted (registered)
//   DbgState            current FSM state for observation
//   bus                 read port and output stream (see register_file_reader_if)
module register_file_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [ADDR_WIDTH-1:0] FirstReg,
  input  logic [ADDR_WIDTH-1:0] LastReg,
  output logic                  Busy,
  output logic                  Done,
  output logic [1:0]            DbgState,
  register_file_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          cur_d   = FirstReg;
          last_d  = LastReg;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // ReadData is combinational from cur_q; sampling here gives the value
        // from before any write committing at this same edge.
        out_data_d  = bus.ReadData;
        out_index_d = cur_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid_q && bus.OutReady) begin
          out_valid_d = 1'b0;
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Natural wrap from 2^ADDR_WIDTH-1 back to 0.
            cur_d   = cur_q + ADDR_WIDTH'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides Start and the handshake: the pending word is dropped
    // and no Done is produced.
    if (Abort) begin
      state_d     = S_IDLE;
      cur_d       = cur_q;
      last_d      = last_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d == S_READ) || (state_d == S_HOLD);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ReadRegister = cur_q;
  assign bus.OutValid     = out_valid_q;
  assign bus.OutData      = out_data_q;
  assign bus.OutIndex     = out_index_q;
  assign Busy             = busy_q;
  assign Done             = done_q;
  assign DbgState         = state_q;

endmodule

// File: tb/tb_register_file_reader.sv
module tb_register_file_reader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int W  = AW + DW;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic          Start, Abort;
  logic [AW-1:0] FirstReg, LastReg;
  logic          Busy, Done;
  logic [1:0]    DbgState;

  register_file_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  register_file_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Abort    (Abort),
    .FirstReg (FirstReg),
    .LastReg  (LastReg),
    .Busy     (Busy),
    .Done     (Done),
    .DbgState (DbgState),
    .bus      (bus.master)
  );

  // Register file model: synchronous write, combinational read.
  logic [DW-1:0] rf [32];
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  always @(posedge Clk) if (we) rf[wa] <= wd;
  assign bus.ReadData = rf[bus.ReadRegister];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            stall_word;  // word index held under OutReady=0, -1 for none
    int            stall_len;
    int            exp_words;   // hand-computed word count
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver tasks ----------------
  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      @(negedge Clk);
      we = 1'b1; wa = AW'(i); wd = 32'h0000_0100 + i;
    end
    @(negedge Clk);
    we = 1'b0;
  endtask

  task automatic run_dump(input vec_t v);
    int e0, k, s, stall_left, busy_cnt;
    bit seen_valid, done_seen;
    logic [AW-1:0] idx;
    exp_q.delete();
    idx = v.first;
    for (int i = 0; i < v.exp_words; i++) begin
      exp_q.push_back({idx, 32'h0000_0100 + {27'b0, idx}});
      idx = idx + AW'(1);
    end
    @(negedge Clk);
    FirstReg = v.first; LastReg = v.last; Start = 1'b1; bus.OutReady = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    e0 = cyc;
    k = 0; s = 0; stall_left = v.stall_len; busy_cnt = 0;
    seen_valid = 0; done_seen = 0;
    for (int g = 0; g < 400 && !done_seen; g++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        check("done_time", 64'(cyc - e0), 64'(2 * v.exp_words + v.stall_len));
        check("words_left", 64'(exp_q.size()), 64'd0);
        done_seen = 1;
      end else if (bus.OutValid) begin
        if (!seen_valid) begin
          check("valid_time", 64'(cyc - e0), 64'(1 + 2 * k + s));
          seen_valid = 1;
        end
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(bus.OutIndex), 64'hFFFF);
        end else begin
          check("word_idx_data", 64'({bus.OutIndex, bus.OutData}), 64'(exp_q[0]));
        end
        if (k == v.stall_word && stall_left > 0) begin
          bus.OutReady = 1'b0;
          stall_left--;
          s++;
        end else begin
          bus.OutReady = 1'b1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          k++;
          seen_valid = 0;
        end
      end
    end
    if (!done_seen) check("done_timeout", 64'd0, 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'(2 * v.exp_words + v.stall_len));
    @(negedge Clk);
    check("done_width", 64'(Done), 64'd0);
    check("idle_after", 64'(DbgState), 64'd0);
  endtask

  // One-word dump of idx; optionally write 0xDEADBEEF to idx at the capture edge.
  task automatic single_read(input logic [AW-1:0] idx, input bit wr, input logic [DW-1:0] exp_data);
    bit got, done_seen;
    @(negedge Clk);
    FirstReg = idx; LastReg = idx; Start = 1'b1; bus.OutReady = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    if (wr) begin
      we = 1'b1; wa = idx; wd = 32'hDEAD_BEEF;
    end
    @(posedge Clk);
    #1 we = 1'b0;
    got = 0; done_seen = 0;
    for (int g = 0; g < 10 && !done_seen; g++) begin
      @(negedge Clk);
      if (bus.OutValid && !got) begin
        check("collide_data", 64'(bus.OutData), 64'(exp_data));
        got = 1;
      end
      if (Done) done_seen = 1;
    end
    check("single_got_word", 64'(got), 64'd1);
    check("single_done", 64'(done_seen), 64'd1);
  endtask

  task automatic abort_seq();
    int e0, accepted;
    bit hit;
    @(negedge Clk);
    FirstReg = 0; LastReg = 31; Start = 1'b1; bus.OutReady = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    e0 = cyc; accepted = 0; hit = 0;
    for (int g = 0; g < 40 && !hit; g++) begin
      @(negedge Clk);
      // Stray Start while busy; must not reload the range.
      Start = ((cyc - e0) == 4);
      FirstReg = (cyc - e0) == 4 ? AW'(20) : AW'(0);
      LastReg  = (cyc - e0) == 4 ? AW'(20) : AW'(31);
      check("abort_no_done", 64'(Done), 64'd0);
      if (bus.OutValid) begin
        check("abort_idx", 64'(bus.OutIndex), 64'(accepted));
        if (accepted < 3) begin
          bus.OutReady = 1'b1;
          accepted++;
        end else begin
          bus.OutReady = 1'b0;
          Abort = 1'b1;
          hit = 1;
        end
      end
    end
    Start = 1'b0;
    if (!hit) check("abort_timeout", 64'd0, 64'd1);
    @(posedge Clk);
    #1 Abort = 1'b0;
    bus.OutReady = 1'b1;
    @(negedge Clk);
    check("abort_outvalid", 64'(bus.OutValid), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_state", 64'(DbgState), 64'd0);
  endtask

  task automatic reset_seq();
    bit hit;
    hit = 0;
    @(negedge Clk);
    FirstReg = 0; LastReg = 31; Start = 1'b1; bus.OutReady = 1'b0;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int g = 0; g < 10 && !hit; g++) begin
      @(negedge Clk);
      if (bus.OutValid) hit = 1;
    end
    check("rst_reached_hold", 64'(hit), 64'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_async_outvalid", 64'(bus.OutValid), 64'd0);
    check("rst_async_outdata", 64'(bus.OutData), 64'd0);
    check("rst_async_busy", 64'(Busy), 64'd0);
    check("rst_async_state", 64'(DbgState), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    bus.OutReady = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge Clk);
      check("rst_no_done", 64'({Done, Busy}), 64'd0);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    Start = 0; Abort = 0; FirstReg = 0; LastReg = 0;
    bus.OutReady = 1'b0; we = 0; wa = 0; wd = 0;

    vecs[0] = '{first: 5'd0,  last: 5'd31, stall_word: -1, stall_len: 0, exp_words: 32};
    vecs[1] = '{first: 5'd0,  last: 5'd31, stall_word: 3,  stall_len: 5, exp_words: 32};
    vecs[2] = '{first: 5'd30, last: 5'd1,  stall_word: -1, stall_len: 0, exp_words: 4};
    vecs[3] = '{first: 5'd7,  last: 5'd7,  stall_word: -1, stall_len: 0, exp_words: 1};
    vecs[4] = '{first: 5'd5,  last: 5'd4,  stall_word: -1, stall_len: 0, exp_words: 32};

    repeat (2) @(negedge Clk);
    check("reset_outvalid", 64'(bus.OutValid), 64'd0);
    check("reset_outdata", 64'(bus.OutData), 64'd0);
    check("reset_outindex", 64'(bus.OutIndex), 64'd0);
    check("reset_readreg", 64'(bus.ReadRegister), 64'd0);
    check("reset_busy_done", 64'({Busy, Done}), 64'd0);
    check("reset_state", 64'(DbgState), 64'd0);
    Rst_n = 1'b1;

    preload();

    for (int i = 0; i < 5; i++) run_dump(vecs[i]);

    abort_seq();
    run_dump('{first: 5'd0, last: 5'd0, stall_word: -1, stall_len: 0, exp_words: 1});

    reset_seq();

    single_read(5'd9, 1'b1, 32'h0000_0109);
    single_read(5'd9, 1'b0, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
